// File: rtl/shift_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational 32-bit shifter.
// Each operation runs as accept -> issue -> response, with one operation in flight at a time.
module shift_arbiter #(
    parameter int PRIO_INIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_data,
    input  logic [4:0]       req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_data,
    input  logic [4:0]       req1_amt,
    output logic [31:0]      sh_in,
    output logic [4:0]       sh_amt,
    output logic             sh_lsl,
    output logic             sh_lsr,
    output logic             sh_asr,
    input  logic [31:0]      sh_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic PTR_INIT = 1'(PRIO_INIT != 0);
    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t      state;
    logic        ptr;
    logic [1:0]  op_r;
    logic [31:0] data_r;
    logic [4:0]  amt_r;
    logic        id_r;

    logic        grant0;
    logic        grant1;
    logic [1:0]  sel_op;
    logic [31:0] sel_data;
    logic [4:0]  sel_amt;

    // A lone valid requester wins; on contention the pointer decides.
    assign grant0 = req0_valid & (~req1_valid | ~ptr);
    assign grant1 = req1_valid & (~req0_valid |  ptr);

    // ready is forced low while reset is held, even though the state already reads IDLE.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    assign sel_op   = grant1 ? req1_op   : req0_op;
    assign sel_data = grant1 ? req1_data : req0_data;
    assign sel_amt  = grant1 ? req1_amt  : req0_amt;

    assign sh_in  = data_r;
    assign sh_amt = amt_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PTR_INIT;
            op_r      <= '0;
            data_r    <= '0;
            amt_r     <= '0;
            id_r      <= 1'b0;
            sh_lsl    <= 1'b0;
            sh_lsr    <= 1'b0;
            sh_asr    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        op_r   <= sel_op;
                        data_r <= sel_data;
                        amt_r  <= sel_amt;
                        id_r   <= grant1;
                        ptr    <= ~grant1;
                        // Strobes are registered here so they are high for the whole ISSUE cycle.
                        sh_lsl <= (sel_op == OP_LSL);
                        sh_lsr <= (sel_op == OP_LSR);
                        sh_asr <= (sel_op == OP_ASR);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    sh_lsl    <= 1'b0;
                    sh_lsr    <= 1'b0;
                    sh_asr    <= 1'b0;
                    rsp_data  <= (op_r == OP_ILL) ? '0 : sh_out;
                    rsp_err   <= (op_r == OP_ILL);
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single op, contention, backpressure, illegal op,
// mid-operation reset and counter wrap, with a behavioural shifter on the sh_* port.
module tb_shift_arbiter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [1:0]       req0_op;
    logic [31:0]      req0_data;
    logic [4:0]       req0_amt;
    logic             req1_valid, req1_ready;
    logic [1:0]       req1_op;
    logic [31:0]      req1_data;
    logic [4:0]       req1_amt;
    logic [31:0]      sh_in;
    logic [4:0]       sh_amt;
    logic             sh_lsl, sh_lsr, sh_asr;
    logic [31:0]      sh_out;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_id, rsp_err;
    logic [CNT_W-1:0] ops_done;

    shift_arbiter #(.PRIO_INIT(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .sh_in(sh_in), .sh_amt(sh_amt), .sh_lsl(sh_lsl), .sh_lsr(sh_lsr), .sh_asr(sh_asr),
        .sh_out(sh_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Shared shifter: returns 0 when no strobe is active.
    always_comb begin
        sh_out = '0;
        if (sh_lsl)      sh_out = sh_in << sh_amt;
        else if (sh_lsr) sh_out = sh_in >> sh_amt;
        else if (sh_asr) sh_out = $unsigned($signed(sh_in) >>> sh_amt);
    end

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, then follow the operation through ISSUE and RESP.
    task automatic serve(input logic exp_id, input logic [31:0] exp_data, input logic exp_err,
                         input logic [2:0] exp_strobe, input logic [31:0] exp_in,
                         input logic [4:0] exp_amt, input bit drop);
        int n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 10) begin
            step();
            n++;
        end
        check("grant_seen", 32'(req0_ready | req1_ready), 32'd1);
        check("grant_id", 32'(req1_ready), 32'(exp_id));
        check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        step();
        if (drop) begin
            if (exp_id) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        check("issue_strobes", 32'({sh_lsl, sh_lsr, sh_asr}), 32'(exp_strobe));
        check("issue_sh_in", sh_in, exp_in);
        check("issue_sh_amt", 32'(sh_amt), 32'(exp_amt));
        check("issue_no_ready", 32'(req0_ready | req1_ready), 32'd0);
        check("issue_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_strobes_off", 32'({sh_lsl, sh_lsr, sh_asr}), 32'd0);
        if (rsp_ready) begin
            step();
            exp_cnt++;
            check("ops_done", 32'(ops_done), 32'(exp_cnt));
            check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic pulse_reset();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 32'h0; req0_amt = 5'd0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_data = 32'h0; req1_amt = 5'd0;
        rsp_ready = 1'b1;
        exp_cnt = '0;
        #1;
        check("reset_ready0", 32'(req0_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_strobes", 32'({sh_lsl, sh_lsr, sh_asr}), 32'd0);
        check("reset_sh_in", sh_in, 32'd0);
        check("reset_ops_done", 32'(ops_done), 32'd0);
        step();
        step();
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // Single LSL from requester 0.
        step();
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 32'h0000_0001; req0_amt = 5'd4;
        serve(1'b0, 32'h10, 1'b0, 3'b100, 32'h1, 5'd4, 1'b1);

        // Contention from reset: grants alternate 0,1,0,1 with both held valid.
        pulse_reset();
        req0_valid = 1'b1; req0_op = 2'b01; req0_data = 32'h8000_0000; req0_amt = 5'd31;
        req1_valid = 1'b1; req1_op = 2'b10; req1_data = 32'h8000_0000; req1_amt = 5'd4;
        for (int i = 0; i < 2; i++) begin
            serve(1'b0, 32'h1, 1'b0, 3'b010, 32'h8000_0000, 5'd31, 1'b0);
            serve(1'b1, 32'hF800_0000, 1'b0, 3'b001, 32'h8000_0000, 5'd4, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: response held for several cycles while a request waits.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 32'h0000_00A5; req0_amt = 5'd8;
        serve(1'b0, 32'hA500, 1'b0, 3'b100, 32'hA5, 5'd8, 1'b1);
        req1_valid = 1'b1; req1_op = 2'b00; req1_data = 32'h1; req1_amt = 5'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", rsp_data, 32'hA500);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            check("bp_ops_done", 32'(ops_done), 32'(exp_cnt));
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        exp_cnt++;
        check("bp_ops_done_inc", 32'(ops_done), 32'(exp_cnt));
        check("bp_rsp_done", 32'(rsp_valid), 32'd0);

        // Illegal op from requester 1.
        req1_valid = 1'b1; req1_op = 2'b11; req1_data = 32'hFFFF_FFFF; req1_amt = 5'd3;
        serve(1'b1, 32'h0, 1'b1, 3'b000, 32'hFFFF_FFFF, 5'd3, 1'b1);

        // Reset while in ISSUE; requester 0 wins first so ptr would otherwise favour 1.
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 32'h3; req0_amt = 5'd1;
        #1;
        check("mid_grant", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        check("mid_issue_lsl", 32'(sh_lsl), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_strobes", 32'({sh_lsl, sh_lsr, sh_asr}), 32'd0);
        check("mid_sh_in", sh_in, 32'd0);
        check("mid_sh_amt", 32'(sh_amt), 32'd0);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_ops_done", 32'(ops_done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req0_valid = 1'b1; req0_op = 2'b01; req0_data = 32'h8000_0000; req0_amt = 5'd31;
        req1_valid = 1'b1; req1_op = 2'b10; req1_data = 32'h8000_0000; req1_amt = 5'd4;
        serve(1'b0, 32'h1, 1'b0, 3'b010, 32'h8000_0000, 5'd31, 1'b1);
        serve(1'b1, 32'hF800_0000, 1'b0, 3'b001, 32'h8000_0000, 5'd4, 1'b1);

        // Counter wrap: 17 ops on a 4-bit counter.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            req0_valid = 1'b1; req0_op = 2'b00; req0_data = 32'(i + 1); req0_amt = 5'd1;
            serve(1'b0, 32'((i + 1) * 2), 1'b0, 3'b100, 32'(i + 1), 5'd1, 1'b1);
        end
        check("wrap_ops_done", 32'(ops_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
